// File: rtl/median_filter_pkg.sv
// median_filter_pkg: shared constants and state encoding for the median filter frame controller
// AUX_SOF / AUX_EOL : bit positions of start-of-frame and end-of-line in the video aux field
// state_t           : frame sequencer states
package median_filter_pkg;
  localparam int AUX_SOF = 0;
  localparam int AUX_EOL = 1;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/median_filter_geom_chk.sv
// median_filter_geom_chk: column/row counters for frame tracking and geometry error detection
// clk, rstb : clock, asynchronous active-low reset
// beat      : accepted input pixel (valid & ready)
// sof, eol  : aux flags of that pixel
// byp       : bypass tracking mode (frame boundaries only, no error checks)
// arm, run  : enabled-frame modes; arm waits for SOF, run checks every beat
// iw, ih    : geometry to check against (ih is the live value while bypassing)
// in_frame  : a bypass frame is in progress
// last      : this beat is the EOL of the final line
// err       : this beat violates the frame geometry
module median_filter_geom_chk #(
  parameter int DW_MD = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             beat,
  input  logic             sof,
  input  logic             eol,
  input  logic             byp,
  input  logic             arm,
  input  logic             run,
  input  logic [DW_MD-1:0] iw,
  input  logic [DW_MD-1:0] ih,
  output logic             in_frame,
  output logic             last,
  output logic             err
);
  localparam logic [DW_MD-1:0] ONE = 1;
  logic [DW_MD-1:0] col, row, cur_col, cur_row;
  logic start, act;
  // A frame-opening SOF is treated as a beat arriving at col 0 of row 0 so that an
  // SOF+EOL pixel (single-column image) goes through the ordinary EOL rule.
  always_comb begin
    start   = sof & (arm | (byp & ~in_frame));
    act     = beat & (start | run | (byp & in_frame));
    cur_col = start ? '0 : col;
    cur_row = start ? '0 : row;
    last    = act & eol & (cur_row == ih - ONE);
    err     = act & (arm | run) &
              ((sof & run) | (eol ? (cur_col != iw - ONE) : (cur_col + ONE == iw)));
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      col      <= '0;
      row      <= '0;
      in_frame <= 1'b0;
    end else if (act) begin
      col      <= eol ? '0 : cur_col + ONE;
      row      <= last ? '0 : eol ? cur_row + ONE : cur_row;
      in_frame <= byp ? ~last : in_frame;
    end
  end
endmodule

// File: rtl/median_filter_frame_ctrl.sv
// median_filter_frame_ctrl: frame-level sequencer applying filter enable only at frame boundaries
// clk, rstb          : clock, asynchronous active-low reset
// en_req, iw, ih     : requested enable and image geometry from the config block
// clr_err            : one-cycle pulse clearing the sticky error flags
// s_val/s_rdy/s_aux  : observed input video bus handshake and aux (SOF/EOL)
// m_val/m_rdy        : observed output video bus handshake
// en                 : applied enable for the bypass mux
// rstb_int           : active-low soft reset to the datapath, low during FLUSH
// in_hold            : forces the input ready low (FLUSH and DRAIN)
// busy               : sequencer is not IDLE
// frame_done         : pulse after the last output pixel of an enabled frame
// frame_cnt          : completed enabled frames, wrapping
// err_geom/err_timeout/err_cfg : sticky geometry, drain-stall and config errors
module median_filter_frame_ctrl
  import median_filter_pkg::*;
#(
  parameter int DW_VX     = 4,
  parameter int DW_MD     = 16,
  parameter int FLUSH_CYC = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en_req,
  input  logic [DW_MD-1:0] iw,
  input  logic [DW_MD-1:0] ih,
  input  logic             clr_err,
  input  logic             s_val,
  input  logic             s_rdy,
  input  logic [DW_VX-1:0] s_aux,
  input  logic             m_val,
  input  logic             m_rdy,
  output logic             en,
  output logic             rstb_int,
  output logic             in_hold,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             err_geom,
  output logic             err_timeout,
  output logic             err_cfg
);
  state_t state, nxt;
  logic in_beat, out_beat, sof, eol, cfg_ok, done, tmo, cfg_err;
  logic in_frame, last, geom_err;
  logic [DW_MD-1:0] iw_l, ih_l;
  logic [2*DW_MD-1:0] total, out_cnt, out_nxt;
  logic [31:0] flush_cnt, stall;
  logic unused_aux;
  assign unused_aux = ^s_aux;
  median_filter_geom_chk #(.DW_MD(DW_MD)) u_geom (
    .clk     (clk),
    .rstb    (rstb),
    .beat    (in_beat),
    .sof     (sof),
    .eol     (eol),
    .byp     (state == ST_IDLE),
    .arm     (state == ST_ARM),
    .run     (state == ST_RUN),
    .iw      (iw_l),
    .ih      (state == ST_IDLE ? ih : ih_l),
    .in_frame(in_frame),
    .last    (last),
    .err     (geom_err)
  );
  // Outputs are registered from the next state so they always line up with state.
  always_comb begin
    in_beat  = s_val & s_rdy;
    out_beat = m_val & m_rdy;
    sof      = s_aux[AUX_SOF];
    eol      = s_aux[AUX_EOL];
    cfg_ok   = (iw != '0) && (ih != '0);
    out_nxt  = out_cnt + (2*DW_MD)'(out_beat);
    done     = (state == ST_DRAIN) && (out_nxt >= total);
    tmo      = (state == ST_DRAIN) && !done && !out_beat && (stall == TIMEOUT - 1);
    cfg_err  = (state == ST_IDLE) && en_req && !cfg_ok;
    nxt      = state;
    case (state)
      // A SOF accepted in the deciding cycle would start a bypass frame we then cut off.
      ST_IDLE:  nxt = (en_req && cfg_ok && !in_frame && !(in_beat && sof)) ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: nxt = (flush_cnt == FLUSH_CYC - 1) ? ((en_req && cfg_ok) ? ST_ARM : ST_IDLE) : ST_FLUSH;
      // A SOF beat already taken by the datapath wins over a falling en_req.
      ST_ARM:   nxt = (in_beat && sof) ? (last ? ST_DRAIN : ST_RUN) : en_req ? ST_ARM : ST_IDLE;
      ST_RUN:   nxt = last ? ST_DRAIN : ST_RUN;
      ST_DRAIN: nxt = done ? ((en_req && cfg_ok) ? ST_ARM : ST_FLUSH) : tmo ? ST_FLUSH : ST_DRAIN;
      default:  nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      en          <= 1'b0;
      rstb_int    <= 1'b0;
      in_hold     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      err_geom    <= 1'b0;
      err_timeout <= 1'b0;
      err_cfg     <= 1'b0;
      flush_cnt   <= '0;
      stall       <= '0;
      out_cnt     <= '0;
      iw_l        <= '0;
      ih_l        <= '0;
      total       <= '0;
    end else begin
      state       <= nxt;
      en          <= nxt inside {ST_ARM, ST_RUN, ST_DRAIN};
      rstb_int    <= nxt != ST_FLUSH;
      in_hold     <= nxt inside {ST_FLUSH, ST_DRAIN};
      busy        <= nxt != ST_IDLE;
      frame_done  <= done;
      frame_cnt   <= frame_cnt + 16'(done);
      err_geom    <= geom_err | (err_geom & ~clr_err);
      err_timeout <= tmo | (err_timeout & ~clr_err);
      err_cfg     <= cfg_err | (err_cfg & ~clr_err);
      flush_cnt   <= (state == ST_FLUSH) ? flush_cnt + 1 : '0;
      stall       <= (state == ST_DRAIN && !out_beat) ? stall + 1 : '0;
      out_cnt     <= (state inside {ST_ARM, ST_RUN, ST_DRAIN} && !done && !tmo) ? out_nxt : '0;
      if (nxt == ST_ARM && state != ST_ARM) begin
        iw_l  <= iw;
        ih_l  <= ih;
        total <= {{DW_MD{1'b0}}, iw} * {{DW_MD{1'b0}}, ih};
      end
    end
  end
endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// tb_median_filter_frame_ctrl: scoreboard bench for the median filter frame controller
module tb_median_filter_frame_ctrl;
  localparam logic [3:0] NO = 4'b0000, SOF = 4'b0001, EOL = 4'b0010, SE = 4'b0011;
  logic clk = 0, rstb = 0, en_req = 0, clr_err = 0;
  logic s_val = 0, s_rdy, m_val = 0, m_rdy = 0;
  logic [15:0] iw = 16'd4, ih = 16'd3;
  logic [3:0] s_aux = '0;
  logic en, rstb_int, in_hold, busy, frame_done, err_geom, err_timeout, err_cfg;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0, done_n = 0;
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  assign s_rdy = ~in_hold;
  median_filter_frame_ctrl #(.DW_VX(4), .DW_MD(16), .FLUSH_CYC(4), .TIMEOUT(16)) dut (
    .clk(clk), .rstb(rstb), .en_req(en_req), .iw(iw), .ih(ih), .clr_err(clr_err),
    .s_val(s_val), .s_rdy(s_rdy), .s_aux(s_aux), .m_val(m_val), .m_rdy(m_rdy),
    .en(en), .rstb_int(rstb_int), .in_hold(in_hold), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err_geom(err_geom), .err_timeout(err_timeout), .err_cfg(err_cfg)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] aux);
    int n = 0;
    s_val = 1'b1;
    s_aux = aux;
    while (!s_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_rdy_wait", n, 0);
    @(negedge clk);
    s_val = 1'b0;
  endtask
  task automatic row(input int n, input logic first);
    for (int c = 0; c < n; c++) send(((c == 0 && first) ? SOF : NO) | ((c == n - 1) ? EOL : NO));
  endtask
  task automatic ret(input int n);
    m_val = 1'b1;
    m_rdy = 1'b1;
    repeat (n) @(negedge clk);
    m_val = 1'b0;
    m_rdy = 1'b0;
  endtask
  task automatic wait_en(input string tag);
    int lo = 0, n = 0;
    while (!en && n < 50) begin
      @(negedge clk);
      lo += (rstb_int == 1'b0) ? 1 : 0;
      n++;
    end
    chk({tag, "_en"}, en, 1);
    chk({tag, "_flush_low"}, lo, 4);
  endtask
  task automatic clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rstb && frame_done) begin
      done_n++;
      chk("sb_nonempty_on_done", sb.size() != 0, 1);
      if (sb.size() != 0) chk("frame_cnt", frame_cnt, sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_rstb_int", rstb_int, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_hold", in_hold, 0);
    rstb = 1'b1;
    @(negedge clk);
    chk("rel_rstb_int", rstb_int, 1);
    chk("rel_cnt", frame_cnt, 0);
    chk("rel_errs", {err_geom, err_timeout, err_cfg}, 0);
    // single enabled 4x3 frame
    en_req = 1'b1;
    wait_en("t1");
    chk("t1_arm_hold", in_hold, 0);
    sb.push_back(16'd1);
    for (int r = 0; r < 3; r++) row(4, r == 0);
    chk("t1_drain_hold", in_hold, 1);
    ret(12);
    @(negedge clk);
    chk("t1_done_n", done_n, 1);
    chk("t1_errs", {err_geom, err_timeout, err_cfg}, 0);
    en_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_idle_en", en, 0);
    chk("t1_idle_busy", busy, 0);
    // bad config
    ih = 16'd0;
    en_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_err_cfg", err_cfg, 1);
    chk("t5_en", en, 0);
    chk("t5_busy", busy, 0);
    en_req = 1'b0;
    ih = 16'd3;
    clr();
    chk("t5_cfg_clr", err_cfg, 0);
    // enable requested in the middle of a bypass frame
    row(4, 1'b1);
    send(NO);
    send(NO);
    en_req = 1'b1;
    send(NO);
    send(EOL);
    chk("t2_en_mid", en, 0);
    row(4, 1'b0);
    chk("t2_en_last_eol", en, 0);
    chk("t2_busy_last_eol", busy, 0);
    wait_en("t2");
    // misplaced EOL
    sb.push_back(16'd2);
    send(SOF);
    send(NO);
    send(EOL);
    chk("t3_geom_set", err_geom, 1);
    row(4, 1'b0);
    row(4, 1'b0);
    ret(12);
    @(negedge clk);
    chk("t3_geom_sticky", err_geom, 1);
    chk("t3_done_n", done_n, 2);
    clr();
    chk("t3_geom_clr", err_geom, 0);
    // 1x2 frames back to back
    en_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_idle", busy, 0);
    iw = 16'd1;
    ih = 16'd2;
    en_req = 1'b1;
    wait_en("t6");
    chk("t6_hold_arm0", in_hold, 0);
    for (int f = 0; f < 2; f++) begin
      sb.push_back(16'(3 + f));
      send(SE);
      send(EOL);
      chk("t6_hold_drain", in_hold, 1);
      ret(2);
      chk("t6_hold_arm", in_hold, 0);
      chk("t6_no_reflush", rstb_int, 1);
    end
    @(negedge clk);
    chk("t6_done_n", done_n, 4);
    chk("t6_geom", err_geom, 0);
    chk("t6_cnt", frame_cnt, 4);
    // stalled drain
    send(SE);
    send(EOL);
    en_req = 1'b0;
    chk("t4_en_drain", en, 1);
    m_val = 1'b1;
    n = 0;
    while (!err_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_cycles", n, 16);
    chk("t4_flush", rstb_int, 0);
    m_val = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_busy", busy, 0);
    chk("t4_en", en, 0);
    chk("t4_err_sticky", err_timeout, 1);
    chk("t4_cnt", frame_cnt, 4);
    clr();
    chk("t4_err_clr", err_timeout, 0);
    chk("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/median_filter_frame_ctrl.md
Name: median_filter_frame_ctrl

Overview:
Frame-level sequencer for the median filter datapath. It decides when filtering turns on and off, and applies enable changes only at frame boundaries. It issues the internal soft reset (rstb_int) to the buffer/filter/tx chain before each enabled run, and checks frame geometry and drain progress. It sits between the configuration register block (en_req, iw, ih) and the top-level bypass mux, and observes both video bus handshakes.

Parameters:
DW_VX, 4, aux width; bit0 = SOF, bit1 = EOL.
DW_MD, 16, width of iw/ih and line/pixel counters.
FLUSH_CYC, 4, cycles rstb_int is held low per flush (>=1).
TIMEOUT, 65535, max cycles without an output beat while draining before err_timeout.

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
en_req  in  1  requested filter enable (config register)
iw  in  DW_MD  image width in pixels
ih  in  DW_MD  image height in lines
clr_err  in  1  clears sticky error flags, 1-cycle pulse
s_val  in  1  observed slave bus valid (top-level s_vb_val)
s_rdy  in  1  observed slave bus ready (top-level s_vb_rdy)
s_aux  in  DW_VX  observed slave bus aux
m_val  in  1  observed master bus valid
m_rdy  in  1  observed master bus ready
en  out  1  applied enable driving the bypass mux
rstb_int  out  1  soft reset to datapath sub-blocks, active-low
in_hold  out  1  forces top-level s_vb_rdy low while high
busy  out  1  high in any state except IDLE
frame_done  out  1  1-cycle pulse when last output pixel of an enabled frame transfers
frame_cnt  out  16  enabled frames completed, wraps at 2^16
err_geom  out  1  sticky: EOL/SOF misplaced vs iw/ih
err_timeout  out  1  sticky: drain stalled for TIMEOUT cycles
err_cfg  out  1  sticky: en_req=1 with iw=0 or ih=0

Behaviour:
- Beat definitions: in_beat = s_val & s_rdy; out_beat = m_val & m_rdy.
- Reset values: state IDLE, en=0, rstb_int=0, in_hold=0, busy=0, frame_done=0, frame_cnt=0, all errors 0, all counters 0. rstb_int rises on the first clk after reset release. All outputs are registered.
- Bypass tracking (IDLE): in_frame sets on an in_beat with SOF. It clears on an in_beat with EOL when row==ih-1; row counts EOL beats while in_frame.
- IDLE: if en_req=1 and iw,ih!=0 and in_frame=0, go to FLUSH. If en_req=1 and iw or ih is 0, set err_cfg and stay in IDLE.
- FLUSH: in_hold=1, rstb_int=0 for exactly FLUSH_CYC cycles, then go to ARM if en_req=1, else IDLE.
- ARM: latch iw_l, ih_l and total=iw_l*ih_l (2*DW_MD bits). en=1, in_hold=0. On an in_beat with SOF, go to RUN with col=1 and row=0. If that beat also has EOL (iw=1), apply the EOL rule in the same cycle.
- RUN: count col per in_beat; EOL resets col and increments row.
  - err_geom if EOL arrives with col!=iw_l-1, if col reaches iw_l without EOL, or if SOF arrives mid-frame. The frame continues on a geometry error.
  - Go to DRAIN on the in_beat carrying EOL with row==ih_l-1.
- Output counting: out_cnt counts out_beats from ARM onward, concurrently with RUN.
- DRAIN: in_hold=1, so no next-frame pixels enter before completion. When out_cnt reaches total on an out_beat: frame_done=1 the next cycle, frame_cnt++, out_cnt=0.
  - Then if en_req=1, go to ARM (datapath is not re-flushed).
  - If en_req=0, go to FLUSH, then IDLE with en=0.
- Timeout: a stall counter resets on each out_beat. Reaching TIMEOUT in DRAIN sets err_timeout and forces FLUSH, then IDLE or ARM per en_req.
- en_req falling during ARM (before SOF) goes to IDLE immediately with en=0. Falling during RUN/DRAIN is deferred to frame end.
- iw/ih changes after ARM are ignored until the next ARM.
- clr_err clears all errors. If an error set condition occurs in the same cycle, the set wins.
- en changes state only on a registered edge, never mid-beat.

Decomposition:
- Package median_filter_pkg: AUX_SOF=0 and AUX_EOL=1 bit indices; state encoding localparams ST_IDLE, ST_FLUSH, ST_ARM, ST_RUN, ST_DRAIN.
- One natural sub-module: median_filter_geom_chk, holding the col/row counters and the err_geom logic. It is shared by bypass tracking and RUN.

Test Plan:
1. iw=4, ih=3, en_req=1 from reset, one 12-pixel frame with correct SOF/EOL, output returns 12 beats -> rstb_int low 4 cycles, single frame_done, frame_cnt=1, no errors.
2. Raise en_req mid bypass frame (row 1 of 3) -> en stays 0 until the EOL of row 2, then FLUSH, then ARM.
3. EOL at col 2 with iw=4 -> err_geom=1 and stays set; clr_err -> 0.
4. Drain with m_rdy=0 held, TIMEOUT=16 -> err_timeout after 16 cycles; FLUSH; IDLE if en_req=0.
5. en_req=1 with ih=0 -> err_cfg=1, state stays IDLE, en=0.
6. iw=1, ih=2 (SOF+EOL on same beat), back-to-back frames with en_req held -> frame_cnt=2, no err_geom, in_hold high only in DRAIN.
